// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: primes a sample FIFO from the bus side, then
// paces refill fetches by credits earned from I2S sender sample requests.
module audio_sample_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  input  logic        req_tick,
  input  logic        req_mode,
  output logic        audio_start_out,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [4:0]  fifo_level,
  output logic [7:0]  underrun_count
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DepthLvl = 5'(FIFO_DEPTH);
  localparam logic [4:0]  PrimeLvl = 5'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic [4:0]      credits_q, credits_d;
  logic            outst_q, outst_d;
  logic            start_out_q, start_out_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [7:0]      underrun_q, underrun_d;

  logic            push, pop, bypass, underrun, issue, stop_now, pop_req, wr_en;
  logic [5:0]      credit_add, credit_sum;

  // Next-state, FIFO bookkeeping, fetch issue and sender-side output
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    credits_d   = '0;
    outst_d     = outst_q;
    start_out_d = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    underrun_d  = underrun_q;
    credit_add  = '0;
    credit_sum  = '0;
    issue       = 1'b0;

    // An ack only counts when a fetch is actually in flight.
    push     = fetch_ack && outst_q;
    stop_now = stop && (state_q == StPrime || state_q == StRun);
    pop_req  = req_tick && (state_q == StRun || state_q == StDrain);
    pop      = pop_req && (level_q != 5'd0);
    // Empty FIFO with a sample arriving this cycle: hand it straight through.
    bypass   = pop_req && (level_q == 5'd0) && push;
    underrun = req_tick && (state_q == StRun) && (level_q == 5'd0) && !push;
    wr_en    = push && !bypass;

    // Single outstanding fetch; never re-issue in the ack cycle so the
    // request visibly drops for a cycle after every ack.
    if (!outst_q && !stop_now) begin
      if (state_q == StPrime) begin
        issue = level_q < PrimeLvl;
      end else if (state_q == StRun) begin
        issue = (credits_q != 5'd0) && (level_q < DepthLvl);
      end
    end

    if (issue) begin
      outst_d = 1'b1;
    end else if (push) begin
      outst_d = 1'b0;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + {4'b0, wr_en} - {4'b0, pop};

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = fetch_data;
    end else if (underrun) begin
      out_valid_d = 1'b1;
      if (underrun_q != 8'hFF) begin
        underrun_d = underrun_q + 8'd1;
      end
    end

    // Credits only accumulate while running; anything else clears them.
    if (state_q == StRun && !stop_now) begin
      credit_add = req_tick ? (req_mode ? 6'd2 : 6'd1) : 6'd0;
      credit_sum = {1'b0, credits_q} - {5'b0, issue} + credit_add;
      credits_d  = (credit_sum > {1'b0, DepthLvl}) ? DepthLvl : credit_sum[4:0];
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPrime;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          level_d    = '0;
          underrun_d = '0;
        end
      end
      StPrime: begin
        if (stop_now) begin
          state_d = StDrain;
        end else if (level_q >= PrimeLvl) begin
          state_d     = StRun;
          start_out_d = 1'b1;
        end
      end
      StRun: begin
        if (stop_now) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (level_q == 5'd0 && !outst_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      credits_q   <= '0;
      outst_q     <= 1'b0;
      start_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      credits_q   <= credits_d;
      outst_q     <= outst_d;
      start_out_q <= start_out_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      underrun_q  <= underrun_d;
    end
  end

  // Sample storage; contents are don't-care while pointers are reset
  always_ff @(posedge in_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= fetch_data;
    end
  end

  assign fetch_req       = outst_q;
  assign audio_start_out = start_out_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign busy            = (state_q != StIdle);
  assign fifo_level      = level_q;
  assign underrun_count  = underrun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler: priming, refill, credit
// saturation, underruns, drain on stop and reset during a fetch.
module tb_audio_sample_scheduler;

  logic        in_clk = 1'b0;
  logic        reset, start, stop, fetch_ack, req_tick, req_mode;
  logic [31:0] fetch_data;
  logic        fetch_req, audio_start_out, out_valid, busy;
  logic [31:0] out_data;
  logic [4:0]  fifo_level;
  logic [7:0]  underrun_count;

  int n_pass   = 0;
  int n_total  = 0;
  int next_smp = 0;
  int exp_pop  = 0;

  audio_sample_scheduler #(
    .FIFO_DEPTH (8),
    .PRIME_LEVEL(4)
  ) dut (
    .in_clk         (in_clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .fetch_req      (fetch_req),
    .fetch_ack      (fetch_ack),
    .fetch_data     (fetch_data),
    .req_tick       (req_tick),
    .req_mode       (req_mode),
    .audio_start_out(audio_start_out),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [31:0] smp(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  // Bus model: ack arrives in the third cycle fetch_req is seen high.
  task automatic serve();
    int waited = 0;
    while (fetch_req !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("fetch_req_rise", 32'(fetch_req), 32'd1);
    step();
    check("fetch_req_hold1", 32'(fetch_req), 32'd1);
    step();
    check("fetch_req_hold2", 32'(fetch_req), 32'd1);
    fetch_ack  = 1'b1;
    fetch_data = smp(next_smp);
    next_smp++;
    step();
    fetch_ack  = 1'b0;
    fetch_data = 32'hDEAD_BEEF;
    check("fetch_req_drop", 32'(fetch_req), 32'd0);
  endtask

  task automatic tick(input logic mode);
    req_tick = 1'b1;
    req_mode = mode;
    step();
    req_tick = 1'b0;
    req_mode = 1'b0;
  endtask

  task automatic expect_pop();
    check("pop_valid", 32'(out_valid), 32'd1);
    check("pop_data", out_data, smp(exp_pop));
    exp_pop++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; fetch_ack = 1'b0;
    req_tick = 1'b0; req_mode = 1'b0; fetch_data = '0;
    step();
    step();
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_audio_start", 32'(audio_start_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_underrun", 32'(underrun_count), 32'd0);
    reset = 1'b0;
    step();

    // Priming: exactly four fetches, then one start pulse
    start = 1'b1;
    step();
    start = 1'b0;
    check("prime_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("prime_no_start", 32'(audio_start_out), 32'd0);
      serve();
      check("prime_level", 32'(fifo_level), 32'(i + 1));
    end
    check("prime_start_wait", 32'(audio_start_out), 32'd0);
    step();
    check("start_pulse", 32'(audio_start_out), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    check("no_fifth_fetch0", 32'(fetch_req), 32'd0);
    step();
    check("start_pulse_end", 32'(audio_start_out), 32'd0);
    check("no_fifth_fetch1", 32'(fetch_req), 32'd0);

    // Start while running must not flush
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_lvl", 32'(fifo_level), 32'd4);
    check("start_ignored_pulse", 32'(audio_start_out), 32'd0);

    // One tick: first sample out, one refill
    tick(1'b0);
    expect_pop();
    check("refill_lvl_dip", 32'(fifo_level), 32'd3);
    step();
    check("pop_valid_1cyc", 32'(out_valid), 32'd0);
    check("refill_req", 32'(fetch_req), 32'd1);
    serve();
    check("refill_lvl", 32'(fifo_level), 32'd4);
    step();
    check("refill_only_one", 32'(fetch_req), 32'd0);

    // Burst-mode ticks with prompt bus: level climbs to 8
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      expect_pop();
      serve();
      serve();
      check("climb_lvl", 32'(fifo_level), 32'(5 + i));
    end
    step();
    check("full_no_fetch", 32'(fetch_req), 32'd0);

    // Five burst ticks at level 8, bus withheld: credits saturate
    req_tick = 1'b1;
    req_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_pop();
    end
    req_tick = 1'b0;
    req_mode = 1'b0;
    check("burst_lvl", 32'(fifo_level), 32'd3);
    check("burst_fetch_req", 32'(fetch_req), 32'd1);
    check("credit_saturate", 32'(dut.credits_q), 32'd8);
    for (int i = 0; i < 5; i++) begin
      serve();
      check("burst_refill_lvl", 32'(fifo_level), 32'(4 + i));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_with_credits", 32'(fetch_req), 32'd0);
    end
    tick(1'b0);
    expect_pop();
    step();
    check("fetch_resumes", 32'(fetch_req), 32'd1);
    serve();
    check("resume_lvl", 32'(fifo_level), 32'd8);

    // Drain to empty with bus withheld, then underruns
    req_tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_pop();
    end
    check("empty_lvl", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("underrun_valid", 32'(out_valid), 32'd1);
      check("underrun_data", out_data, 32'd0);
    end
    check("underrun_cnt3", 32'(underrun_count), 32'd3);
    repeat (300) step();
    req_tick = 1'b0;
    check("underrun_sat", 32'(underrun_count), 32'd255);
    check("underrun_sat_valid", 32'(out_valid), 32'd1);
    check("underrun_fetch_pending", 32'(fetch_req), 32'd1);

    // Stop while a fetch is in flight at level 2
    serve();
    serve();
    step();
    check("pre_stop_lvl", 32'(fifo_level), 32'd2);
    check("pre_stop_req", 32'(fetch_req), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_req_held", 32'(fetch_req), 32'd1);
    fetch_ack  = 1'b1;
    fetch_data = smp(next_smp);
    next_smp++;
    step();
    fetch_ack = 1'b0;
    check("drain_push_lvl", 32'(fifo_level), 32'd3);
    check("drain_req_drop", 32'(fetch_req), 32'd0);
    step();
    check("drain_no_fetch", 32'(fetch_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      expect_pop();
      check("drain_no_fetch_tick", 32'(fetch_req), 32'd0);
    end
    check("drain_empty", 32'(fifo_level), 32'd0);
    tick(1'b0);
    check("drain_empty_no_valid", 32'(out_valid), 32'd0);
    check("drain_to_idle", 32'(busy), 32'd0);
    check("idle_no_fetch", 32'(fetch_req), 32'd0);
    tick(1'b1);
    check("idle_tick_ignored", 32'(out_valid), 32'd0);
    step();
    check("idle_tick_no_fetch", 32'(fetch_req), 32'd0);

    // Stop alone in IDLE is ignored; start with stop acts as start
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("idle_stop_ignored", 32'(busy), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd1);
    check("start_clears_underrun", 32'(underrun_count), 32'd0);
    exp_pop = next_smp;
    for (int i = 0; i < 4; i++) serve();
    check("reprime_lvl", 32'(fifo_level), 32'd4);
    step();
    check("reprime_start", 32'(audio_start_out), 32'd1);

    // Reset mid-run with a fetch outstanding
    tick(1'b0);
    expect_pop();
    step();
    check("mid_run_req", 32'(fetch_req), 32'd1);
    tick(1'b0);
    expect_pop();
    check("mid_run_req2", 32'(fetch_req), 32'd1);
    reset = 1'b1;
    step();
    check("mrst_fetch_req", 32'(fetch_req), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data", out_data, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_start", 32'(audio_start_out), 32'd0);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_underrun", 32'(underrun_count), 32'd0);
    reset      = 1'b0;
    fetch_ack  = 1'b1;
    fetch_data = 32'h1234_5678;
    step();
    fetch_ack = 1'b0;
    check("late_ack_level", 32'(fifo_level), 32'd0);
    check("late_ack_req", 32'(fetch_req), 32'd0);
    step();
    check("late_ack_idle", 32'(busy), 32'd0);
    check("late_ack_level2", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries, power of two, 4 to 16.
REQ-002 SHALL have parameter PRIME_LEVEL, default 4, FIFO level that ends priming, 1 to FIFO_DEPTH.
REQ-003 SHALL have port in_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins playback.
REQ-006 SHALL have port stop, input, 1, one-cycle pulse that ends playback.
REQ-007 SHALL have port fetch_req, output, 1, sample fetch request to the bus side.
REQ-008 SHALL have port fetch_ack, input, 1, one-cycle strobe; fetch_data is valid in that cycle.
REQ-009 SHALL have port fetch_data, input, 32, fetched stereo sample (L in [31:16], R in [15:0]).
REQ-010 SHALL have port req_tick, input, 1, one-cycle per-frame sample request from the I2S sender.
REQ-011 SHALL have port req_mode, input, 1, sender burst-request mode, sampled together with req_tick.
REQ-012 SHALL have port audio_start_out, output, 1, one-cycle start pulse to the I2S sender.
REQ-013 SHALL have port out_valid, output, 1, one-cycle sample strobe to the sender in_valid.
REQ-014 SHALL have port out_data, output, 32, sample to the sender in_data; valid only with out_valid.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port fifo_level, output, 5, current FIFO occupancy, 0 to FIFO_DEPTH.
REQ-017 SHALL have port underrun_count, output, 8, count of underruns, saturating.

Function
REQ-018 SHALL implement four states, IDLE, PRIME, RUN and DRAIN, and SHALL hold a FIFO_DEPTH x 32 FIFO, a credit counter (0 to FIFO_DEPTH) and an outstanding-fetch flag.
REQ-019 IDLE->PRIME on start; in that same cycle the FIFO SHALL be flushed, credits cleared and underrun_count cleared; start outside IDLE SHALL be ignored.
REQ-020 PRIME SHALL fetch, without needing credits, until fifo_level plus outstanding equals PRIME_LEVEL.
REQ-021 PRIME->RUN in the cycle after fifo_level reaches PRIME_LEVEL; audio_start_out SHALL pulse high for exactly that one transition cycle.
REQ-022 RUN fetching: each req_tick SHALL add 1 credit (2 credits if req_mode=1), saturating at FIFO_DEPTH; a fetch SHALL be issued only when credits>0 and fifo_level+outstanding<FIFO_DEPTH; each issued fetch SHALL consume 1 credit.
REQ-023 Fetch handshake: fetch_req SHALL rise in the cycle after issue and stay high until fetch_ack; fetch_req SHALL be low in the cycle after fetch_ack; at most one fetch SHALL be outstanding; fetch_ack without an outstanding fetch SHALL be ignored.
REQ-024 On fetch_ack, fetch_data SHALL be pushed into the FIFO; a push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-025 In RUN or DRAIN, req_tick with the FIFO non-empty SHALL pop the head and drive it with out_valid=1 in the next cycle (latency 1).
REQ-026 In RUN, req_tick with the FIFO empty and no push in the same cycle SHALL be an underrun: the next cycle SHALL give out_valid=1 and out_data=0, and underrun_count SHALL increment, saturating at 255.
REQ-027 stop in PRIME or RUN SHALL enter DRAIN; no new fetches SHALL be issued in DRAIN, credits SHALL be cleared, and any outstanding fetch SHALL still complete and push.
REQ-028 DRAIN->IDLE once the FIFO is empty and no fetch is outstanding; req_tick on an empty FIFO in DRAIN SHALL produce no out_valid and no underrun.
REQ-029 stop in DRAIN or IDLE SHALL be ignored; start and stop together in IDLE SHALL act as start.
REQ-030 In IDLE, req_tick SHALL be ignored: no out_valid, no credits.

Reset
REQ-031 While reset is high: state=IDLE, FIFO empty, credits=0, outstanding=0; fetch_req, audio_start_out, out_valid, busy = 0; out_data, fifo_level, underrun_count = 0.
REQ-032 Reset during an outstanding fetch SHALL drop fetch_req on the next edge, and a fetch_ack arriving after reset SHALL be ignored.

Verification
REQ-033 Bench SHALL cover: start, bus acks each fetch after 3 cycles, PRIME_LEVEL=4 -> exactly 4 fetches, fifo_level=4, then one audio_start_out pulse, busy=1.
REQ-034 Bench SHALL cover: RUN with level 4, one req_tick with req_mode=0 -> out_valid with the first pushed sample one cycle later, then 1 refill fetch, level returns to 4.
REQ-035 Bench SHALL cover: RUN with level 0 and bus ack withheld, 3 req_ticks -> 3 out_valid pulses with out_data=0 and underrun_count=3; 300 ticks -> count saturates at 255.
REQ-036 Bench SHALL cover: req_tick with req_mode=1, 5 times, at level 8 -> credits saturate at 8, no fetch while level=8, fetches resume as ticks pop.
REQ-037 Bench SHALL cover: stop during an outstanding fetch at level 2 -> ack is pushed (level 3), 3 ticks drain samples in order, then IDLE, busy=0, no further fetch_req.
REQ-038 Bench SHALL cover: reset asserted mid-RUN with fetch_req high -> all outputs 0 next cycle; a late fetch_ack does not change fifo_level.
